// File: rtl/i2c_target_pkg.sv
// Shared types for the I2C target: protocol state encoding and the
// R/W bit value that selects a read transaction.
package i2c_target_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ACK,
        PTR,
        WDATA,
        RDATA,
        MACK,
        WAITSTOP
    } state_t;

    localparam logic I2C_RD = 1'b1;

endpackage

// File: rtl/i2c_line_cond.sv
// Conditions one asynchronous I2C line: 2-flop sync, optional 3-tap
// majority filter (I2C_TARGET_FILTER_EN), history flop, edge detection.
// Ports: clk_i, rst_i (async, active-high), i_line (raw pad sense),
//        o_level (clean level), o_rise / o_fall (1-clk edge strobes).
module i2c_line_cond
    import i2c_target_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic i_line,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [1:0] r_sync;
    logic       r_hist;
    logic       w_level;

    // Lines idle high, so every flop resets to 1 to avoid a fake edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_line};
        end
    end

`ifdef I2C_TARGET_FILTER_EN
    logic [1:0] r_tap;
    logic       r_filt;

    // Majority over the synced sample and two delayed copies; a single
    // clock pulse never reaches two votes. Adds 2 clocks of latency.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tap  <= 2'b11;
            r_filt <= 1'b1;
        end else begin
            r_tap  <= {r_tap[0], r_sync[1]};
            r_filt <= (r_sync[1] & r_tap[0]) |
                      (r_sync[1] & r_tap[1]) |
                      (r_tap[0]  & r_tap[1]);
        end
    end

    assign w_level = r_filt;
`else
    assign w_level = r_sync[1];
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_hist <= 1'b1;
        end else begin
            r_hist <= w_level;
        end
    end

    assign o_level = w_level;
    assign o_rise  = w_level & ~r_hist;
    assign o_fall  = ~w_level & r_hist;

endmodule

// File: rtl/i2c_target.sv
// I2C target with NREGS 8-bit registers behind an auto-incrementing
// pointer, shared with a Wishbone-style bus responder.
// Ports: clk_i, rst_i (async, active-high); scl_i, sda_i pad senses;
//        sda_o (0 = pull low, 1 = release); adr_i, dat_i, dat_o, we_i,
//        sel_i, stb_i, cyc_i, ack_o bus side; wr_irq STOP-after-write.
// Option: I2C_TARGET_FILTER_EN adds a glitch filter on SCL and SDA.
module i2c_target
    import i2c_target_pkg::*;
#(
    parameter logic [6:0] DEVADDR = 7'h1a,
    parameter int          NREGS   = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     scl_i,
    input  logic                     sda_i,
    output logic                     sda_o,
    input  logic [$clog2(NREGS)-1:0] adr_i,
    input  logic [31:0]              dat_i,
    output logic [31:0]              dat_o,
    input  logic                     we_i,
    input  logic [3:0]               sel_i,
    input  logic                     stb_i,
    input  logic                     cyc_i,
    output logic                     ack_o,
    output logic                     wr_irq
);

    localparam int PW = $clog2(NREGS);

    logic w_scl, w_scl_rise, w_scl_fall;
    logic w_sda, w_sda_rise, w_sda_fall;
    logic w_start, w_stop;

    i2c_line_cond u_scl (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .i_line (scl_i),
        .o_level(w_scl),
        .o_rise (w_scl_rise),
        .o_fall (w_scl_fall)
    );

    i2c_line_cond u_sda (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .i_line (sda_i),
        .o_level(w_sda),
        .o_rise (w_sda_rise),
        .o_fall (w_sda_fall)
    );

    assign w_start = w_scl & w_sda_fall;
    assign w_stop  = w_scl & w_sda_rise;

    state_t        r_state, w_state_n;
    state_t        r_after, w_after_n;
    logic [3:0]    r_cnt, w_cnt_n;
    logic [7:0]    r_shift, w_shift_n;
    logic [PW-1:0] r_ptr, w_ptr_n;
    logic          r_sda, w_sda_n;
    logic          r_wrote, w_wrote_n;
    logic          r_irq, w_irq_n;
    logic          w_i2c_we;
    logic          r_ack;
    logic [31:0]   r_dat;
    logic [7:0]    r_regs [NREGS];
    logic          w_bus_req, w_bus_we;
    logic          w_unused;

    assign w_unused = ^{dat_i[31:8], sel_i[3:1]};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_after <= IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_ptr   <= '0;
            r_sda   <= 1'b1;
            r_wrote <= 1'b0;
            r_irq   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_after <= w_after_n;
            r_cnt   <= w_cnt_n;
            r_shift <= w_shift_n;
            r_ptr   <= w_ptr_n;
            r_sda   <= w_sda_n;
            r_wrote <= w_wrote_n;
            r_irq   <= w_irq_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_after_n = r_after;
        w_cnt_n   = r_cnt;
        w_shift_n = r_shift;
        w_ptr_n   = r_ptr;
        w_sda_n   = r_sda;
        w_wrote_n = r_wrote;
        w_irq_n   = 1'b0;
        w_i2c_we  = 1'b0;
        if (w_stop) begin
            w_state_n = IDLE;
            w_sda_n   = 1'b1;
            w_wrote_n = 1'b0;
            w_irq_n   = r_wrote;
        end else if (w_start) begin
            w_state_n = ADDR;
            w_cnt_n   = '0;
            w_sda_n   = 1'b1;
        end else begin
            unique case (r_state)
                IDLE, WAITSTOP: begin
                end
                ADDR, PTR, WDATA: begin
                    // r_cnt[3] marks a full byte waiting for the SCL fall
                    if (w_scl_rise && !r_cnt[3]) begin
                        w_shift_n = {r_shift[6:0], w_sda};
                        w_cnt_n   = r_cnt + 4'd1;
                        if (r_state == ADDR && r_cnt == 4'd7 &&
                            r_shift[6:0] != DEVADDR)
                            w_state_n = IDLE;
                    end else if (w_scl_fall && r_cnt[3]) begin
                        w_cnt_n   = '0;
                        w_sda_n   = 1'b0;
                        w_state_n = ACK;
                        w_after_n = WDATA;
                        if (r_state == ADDR) begin
                            w_after_n = (r_shift[0] == I2C_RD) ? RDATA : PTR;
                        end else if (r_state == PTR) begin
                            w_ptr_n = r_shift[PW-1:0];
                        end else begin
                            w_i2c_we  = 1'b1;
                            w_ptr_n   = r_ptr + 1'b1;
                            w_wrote_n = 1'b1;
                        end
                    end
                end
                ACK: begin
                    if (w_scl_fall) begin
                        w_cnt_n   = '0;
                        w_state_n = r_after;
                        if (r_after == RDATA) begin
                            w_shift_n = r_regs[r_ptr];
                            w_sda_n   = r_regs[r_ptr][7];
                        end else begin
                            w_sda_n = 1'b1;
                        end
                    end
                end
                RDATA: begin
                    if (w_scl_rise) begin
                        w_cnt_n = r_cnt + 4'd1;
                    end else if (w_scl_fall) begin
                        if (r_cnt[3]) begin
                            w_sda_n   = 1'b1;
                            w_ptr_n   = r_ptr + 1'b1;
                            w_cnt_n   = '0;
                            w_state_n = MACK;
                        end else begin
                            w_shift_n = {r_shift[6:0], 1'b0};
                            w_sda_n   = r_shift[6];
                        end
                    end
                end
                MACK: begin
                    // r_cnt = 1 records an initiator ACK until SCL falls
                    if (w_scl_rise) begin
                        if (w_sda) w_state_n = WAITSTOP;
                        else       w_cnt_n   = 4'd1;
                    end else if (w_scl_fall && r_cnt == 4'd1) begin
                        w_cnt_n   = '0;
                        w_state_n = RDATA;
                        w_shift_n = r_regs[r_ptr];
                        w_sda_n   = r_regs[r_ptr][7];
                    end
                end
            endcase
        end
    end

    assign w_bus_req = stb_i & cyc_i;
    assign w_bus_we  = w_bus_req & ~r_ack & we_i & sel_i[0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_bus_req;
            if (w_bus_req) r_dat <= {24'h0, r_regs[adr_i]};
        end
    end

    // The I2C write is last so it wins a same-register collision.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else begin
            if (w_bus_we) r_regs[adr_i] <= dat_i[7:0];
            if (w_i2c_we) r_regs[r_ptr] <= r_shift;
        end
    end

    assign sda_o  = r_sda;
    assign ack_o  = r_ack;
    assign dat_o  = r_dat;
    assign wr_irq = r_irq;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: open-drain I2C initiator model plus
// bus tasks, immediate-assertion checks, one summary line.
module tb_i2c_target;
    import i2c_target_pkg::*;

    localparam int Q = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m_scl = 1'b1;
    logic        m_sda = 1'b1;
    logic        ovr = 1'b0;
    logic        sda_line;
    logic        sda_o;
    logic [3:0]  adr = '0;
    logic [31:0] wdat = '0;
    logic [31:0] dat_o;
    logic        we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic        stb = 1'b0;
    logic        cyc = 1'b0;
    logic        ack_o;
    logic        wr_irq;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int irq_cnt = 0;
    int low_cnt = 0;

    assign sda_line = m_sda & (sda_o | ovr);

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_irq) irq_cnt <= irq_cnt + 1;
        if (!sda_o) low_cnt <= low_cnt + 1;
    end

    i2c_target dut (
        .clk_i (clk),
        .rst_i (rst),
        .scl_i (m_scl),
        .sda_i (sda_line),
        .sda_o (sda_o),
        .adr_i (adr),
        .dat_i (wdat),
        .dat_o (dat_o),
        .we_i  (we),
        .sel_i (sel),
        .stb_i (stb),
        .cyc_i (cyc),
        .ack_o (ack_o),
        .wr_irq(wr_irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_sda = 1'b1; tick(Q);
    endtask

    task automatic send_bits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            m_sda = b[i]; tick(Q);
            m_scl = 1'b1; tick(2 * Q);
            m_scl = 1'b0; tick(Q);
        end
    endtask

    task automatic ack_clock(output logic a);
        m_sda = 1'b1; tick(Q);
        m_scl = 1'b1; tick(Q);
        a = sda_line; tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic a);
        send_bits(b);
        ack_clock(a);
    endtask

    task automatic rd_byte(input logic nack, output logic [7:0] b);
        m_sda = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            tick(Q);
            m_scl = 1'b1; tick(Q);
            b[i] = sda_line; tick(Q);
            m_scl = 1'b0;
        end
        tick(Q);
        m_sda = nack; tick(Q);
        m_scl = 1'b1; tick(2 * Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
        adr = a; wdat = {24'h0, d}; we = 1'b1; sel = 4'h1;
        stb = 1'b1; cyc = 1'b1;
        tick(1);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        tick(1);
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d,
                            output logic ok);
        adr = a; we = 1'b0; sel = 4'hf;
        stb = 1'b1; cyc = 1'b1;
        ok = 1'b0;
        d = '0;
        for (int k = 0; k < 5 && !ok; k++) begin
            tick(1);
            if (ack_o) begin
                ok = 1'b1;
                d = dat_o;
            end
        end
        stb = 1'b0; cyc = 1'b0;
        tick(1);
    endtask

    initial begin
        logic        a;
        logic        ok;
        logic        hit;
        logic [7:0]  rb;
        logic [31:0] rd;
        int          base;

        #12;
        chk("rst_sda", 32'(sda_o), 32'd1);
        chk("rst_ack", 32'(ack_o), 32'd0);
        chk("rst_dat", dat_o, 32'd0);
        chk("rst_irq", 32'(wr_irq), 32'd0);
        #11 rst = 1'b0;
        tick(4);

        // 1: write ptr 3, A5, 5A
        i2c_start();
        wr_byte(8'h34, a); chk("t1_ack_addr", 32'(a), 32'd0);
        wr_byte(8'h03, a); chk("t1_ack_ptr", 32'(a), 32'd0);
        wr_byte(8'ha5, a); chk("t1_ack_d0", 32'(a), 32'd0);
        wr_byte(8'h5a, a); chk("t1_ack_d1", 32'(a), 32'd0);
        i2c_stop();
        tick(4);
        chk("t1_irq", 32'(irq_cnt), 32'd1);
        bus_read(4'd4, rd, ok);
        chk("t1_bus_ack", 32'(ok), 32'd1);
        chk("t1_reg4", rd, 32'h5a);
        chk("t1_ack_drop", 32'(ack_o), 32'd0);
        bus_read(4'd3, rd, ok);
        chk("t1_reg3", rd, 32'ha5);

        // 2: bus preload, pointer write, repeated start, read 2
        bus_write(4'd0, 8'h11);
        bus_write(4'd1, 8'h22);
        i2c_start();
        wr_byte(8'h34, a); chk("t2_ack_addr", 32'(a), 32'd0);
        wr_byte(8'h00, a); chk("t2_ack_ptr", 32'(a), 32'd0);
        i2c_start();
        wr_byte(8'h35, a); chk("t2_ack_raddr", 32'(a), 32'd0);
        rd_byte(1'b0, rb); chk("t2_rd0", 32'(rb), 32'h11);
        rd_byte(1'b1, rb); chk("t2_rd1", 32'(rb), 32'h22);
        chk("t2_release", 32'(sda_o), 32'd1);
        i2c_stop();
        tick(4);
        chk("t2_ptr", 32'(dut.r_ptr), 32'd2);
        chk("t2_no_irq", 32'(irq_cnt), 32'd1);

        // 3: foreign address
        base = low_cnt;
        i2c_start();
        wr_byte(8'h56, a); chk("t3_nack", 32'(a), 32'd1);
        wr_byte(8'h00, a); chk("t3_nack_d", 32'(a), 32'd1);
        i2c_stop();
        tick(4);
        chk("t3_no_drive", 32'(low_cnt), 32'(base));
        bus_read(4'd3, rd, ok);
        chk("t3_reg3", rd, 32'ha5);

        // 4: pointer wrap
        i2c_start();
        wr_byte(8'h34, a);
        wr_byte(8'h0f, a);
        wr_byte(8'h01, a);
        wr_byte(8'h02, a);
        wr_byte(8'h03, a); chk("t4_ack_last", 32'(a), 32'd0);
        i2c_stop();
        tick(4);
        chk("t4_ptr", 32'(dut.r_ptr), 32'd2);
        chk("t4_irq", 32'(irq_cnt), 32'd2);
        bus_read(4'd15, rd, ok); chk("t4_reg15", rd, 32'h01);
        bus_read(4'd0, rd, ok);  chk("t4_reg0", rd, 32'h02);
        bus_read(4'd1, rd, ok);  chk("t4_reg1", rd, 32'h03);

        // 6a: same-cycle bus and I2C write to reg 5
        i2c_start();
        wr_byte(8'h34, a);
        wr_byte(8'h05, a);
        for (int i = 7; i >= 0; i--) begin
            m_sda = rb[0] ^ rb[0] ^ ((8'h77 >> i) & 8'h01) != 0;
            tick(Q);
            m_scl = 1'b1; tick(2 * Q);
            m_scl = 1'b0;
            if (i > 0) tick(Q);
        end
        hit = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin
            @(negedge clk);
            if (dut.w_i2c_we) begin
                adr = 4'd5; wdat = 32'h99; we = 1'b1; sel = 4'h1;
                stb = 1'b1; cyc = 1'b1;
                hit = 1'b1;
            end
        end
        tick(1);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        chk("t6_aligned", 32'(hit), 32'd1);
        ack_clock(a); chk("t6_ack", 32'(a), 32'd0);
        i2c_stop();
        tick(4);
        bus_read(4'd5, rd, ok);
        chk("t6_reg5", rd, 32'h77);

        // 5a: STOP forced during a read byte of reg 7 (= 0)
        i2c_start();
        wr_byte(8'h34, a);
        wr_byte(8'h07, a);
        i2c_start();
        wr_byte(8'h35, a);
        tick(Q);
        m_scl = 1'b1; tick(Q);
        chk("t5_driving", 32'(sda_o), 32'd0);
        m_sda = 1'b0; ovr = 1'b1; tick(2);
        m_sda = 1'b1;
        hit = 1'b0;
        for (int k = 0; k < 12 && !hit; k++) begin
            tick(1);
            if (sda_o) hit = 1'b1;
        end
        chk("t5_stop_rel", 32'(hit), 32'd1);
        chk("t5_idle", 32'(dut.r_state), 32'(IDLE));
        ovr = 1'b0;
        tick(Q);

        // 5b: reset while the address ACK is driven
        i2c_start();
        send_bits(8'h34);
        chk("t5_ack_drv", 32'(sda_o), 32'd0);
        #3 rst = 1'b1;
        #1;
        chk("t5_rst_rel", 32'(sda_o), 32'd1);
        chk("t5_rst_idle", 32'(dut.r_state), 32'(IDLE));
        #20 rst = 1'b0;
        m_sda = 1'b1; m_scl = 1'b1;
        tick(Q);
        bus_read(4'd3, rd, ok);
        chk("t5_rst_reg3", rd, 32'h0);

`ifdef I2C_TARGET_FILTER_EN
        // 6b: 1-clk SCL glitch mid-byte is ignored
        i2c_start();
        for (int i = 7; i >= 5; i--) begin
            m_sda = ((8'h34 >> i) & 8'h01) != 0;
            tick(Q);
            m_scl = 1'b1; tick(2 * Q);
            m_scl = 1'b0; tick(Q);
        end
        m_scl = 1'b1;
        @(posedge clk);
        #1 m_scl = 1'b0;
        tick(Q);
        chk("t6_glitch_cnt", 32'(dut.r_cnt), 32'd3);
        i2c_stop();
        tick(4);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
